dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the CPU memory stage.
- Accepts one read or write request at a time over a valid/ready handshake and holds a byte-addressed, little-endian storage array.
- Returns read data or a write acknowledge after a programmable latency, with an error flag for illegal accesses.
- Used as the backing store when the memory stage is made multi-cycle/stallable.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; power of two, at least 8.
- LATENCY, 2, extra wait cycles between request acceptance and response; legal range 0-15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  64  byte address.
- req_wdata  input  64  write data; the low size*8 bits are used.
- req_size  input  4  transfer size in bytes: 1, 2, 4 or 8.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  64  read data, zero-extended; 0 for writes and errors.
- resp_err  output  1  access was illegal.

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counting down the latency.
  - RESP: resp_valid=1.
- Reset (async, any state):
  - state→IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once reset deasserts.
  - Storage contents are not reset.
  - A write that has not yet committed is discarded.
- Acceptance: on a rising edge in IDLE with req_valid=1.
  - Latch write, addr, wdata and size into request registers.
  - If LATENCY=0, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where counter==0, go to RESP; commit a legal write and capture read data on that same edge.
  - For LATENCY=0, commit and capture happen on the acceptance edge.
- Timing: resp_valid is first high in the cycle after edge t0+LATENCY, where t0 is the acceptance edge.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until an edge with resp_ready=1.
  - On that edge: state→IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready stays low in WAIT and RESP. Only one request is outstanding; the minimum request-to-request spacing is LATENCY+2 cycles.
- Legality: an access is an error if any of the following holds:
  - req_size is not in {1,2,4,8};
  - addr mod size ≠ 0 (misaligned);
  - addr+size > DEPTH_BYTES, computed without 64-bit wrap, so any address with high bits set is an error.
- Errors: a read returns rdata=0; a write modifies no bytes; resp_err=1.
- Read data: byte k of the result equals mem[addr+k] for k < size; upper bytes are 0.
- Write data: mem[addr+k] ← wdata[8k+7:8k] for k < size; all other bytes are unchanged.
- Handshake inputs are ignored when not relevant:
  - req_valid and the request fields while not in IDLE;
  - resp_ready while not in RESP.
  - The request fields may change after acceptance with no effect.
- Simultaneous events: reset asserted in the same cycle as an accept or response handshake wins; no commit occurs.

Test Plan:
- Write, then read back, LATENCY=2:
  - Write addr 0x10, size 8, wdata 0x1122334455667788. Expect resp_valid high in the cycle after edge t0+2, resp_err=0, rdata=0.
  - Read addr 0x10, size 8 → rdata=0x1122334455667788.
- Sub-word accesses:
  - Read addr 0x12, size 2 → 0x0000000000005566.
  - Write addr 0x13, size 1, wdata 0xFF; then read addr 0x10, size 8 → 0x11223344FF667788.
- Errors:
  - Read addr 0x11, size 4 → resp_err=1, rdata=0.
  - Write addr 0x3FC, size 8 with DEPTH 1024 → resp_err=1.
  - req_size 3 → resp_err=1.
  - A read of 0x10 afterwards shows the contents unchanged.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles in RESP: resp_valid, rdata and err stay stable, req_ready=0, and a new req_valid is ignored.
  - Set resp_ready=1: IDLE on the next edge, req_ready=1.
- Reset mid-operation:
  - Write 0xAA to addr 0x20, size 1; assert reset in the WAIT cycle before commit.
  - Expect outputs to clear asynchronously, state IDLE, and a read of 0x20 to return its previous value.
- LATENCY=0 build:
  - Accept a read at edge t0 → resp_valid high in the cycle after t0.
  - Back-to-back requests with resp_ready tied to 1 → one accept every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory request interface.
// Holds a byte-addressed little-endian storage array and serves one read or write at a
// time over a valid/ready handshake, answering after LATENCY extra wait cycles.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write            1 = write, 0 = read
//   req_addr             byte address
//   req_wdata            write data, low req_size*8 bits used
//   req_size             transfer size in bytes (1, 2, 4 or 8; anything else is an error)
//   resp_valid/resp_ready response handshake
//   resp_rdata           zero-extended read data, 0 for writes and errors
//   resp_err             access was illegal (bad size, misaligned or out of range)
module dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW      = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  LatInit = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic        ZeroLat = (LATENCY == 0);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Storage is deliberately outside the reset domain.
    logic [7:0]  mem_q [DEPTH_BYTES];

    // The access being committed: live inputs on a zero-latency accept, latched copy otherwise.
    logic        eff_write;
    logic [63:0] eff_addr;
    logic [63:0] eff_wdata;
    logic [3:0]  eff_size;
    logic [AW-1:0] base;
    logic [3:0]  size_m1;
    logic [64:0] end_addr;
    logic        size_ok, misaligned, out_of_range, acc_err;
    logic [63:0] rd_data;
    logic        do_commit, mem_we;

    always_comb begin
        if (state_q == StIdle) begin
            eff_write = req_write;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_size  = req_size;
        end else begin
            eff_write = wr_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_size  = size_q;
        end
    end

    assign base         = eff_addr[AW-1:0];
    assign size_m1      = eff_size - 4'd1;
    assign size_ok      = (eff_size == 4'd1) || (eff_size == 4'd2) ||
                          (eff_size == 4'd4) || (eff_size == 4'd8);
    assign misaligned   = |(eff_addr[2:0] & size_m1[2:0]);
    // 65-bit sum so addresses near 2^64 cannot wrap back into range.
    assign end_addr     = {1'b0, eff_addr} + 65'(eff_size);
    assign out_of_range = end_addr > 65'(DEPTH_BYTES);
    assign acc_err      = !size_ok || misaligned || out_of_range;

    always_comb begin
        rd_data = '0;
        if (!acc_err) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < eff_size) begin
                    rd_data[8*k +: 8] = mem_q[base + AW'(k)];
                end
            end
        end
    end

    // Reset during the commit cycle suppresses the write.
    assign do_commit = !reset &&
                       ((state_q == StIdle && req_valid && ZeroLat) ||
                        (state_q == StWait && cnt_q == 4'd0));
    assign mem_we    = do_commit && eff_write && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < eff_size) begin
                    mem_q[base + AW'(k)] <= eff_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    if (ZeroLat) begin
                        state_d = StResp;
                        rdata_d = eff_write ? 64'd0 : rd_data;
                        err_d   = acc_err;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    rdata_d = eff_write ? 64'd0 : rd_data;
                    err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle) && !reset;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance share
// the request fields; sel routes valid/ready and the observed outputs to one of them.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_write, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;

    logic        rr2, rv2, re2, rr0, rv0, re0;
    logic [63:0] rd2, rd0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(rr2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(rv2), .resp_ready(resp_ready & ~sel), .resp_rdata(rd2), .resp_err(re2)
    );

    dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(rr0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(rv0), .resp_ready(resp_ready & sel), .resp_rdata(rd0), .resp_err(re0)
    );

    assign req_ready  = sel ? rr0 : rr2;
    assign resp_valid = sel ? rv0 : rv2;
    assign resp_rdata = sel ? rd0 : rd2;
    assign resp_err   = sel ? re0 : re2;

    // Called at posedge+1. Returns data, error and edges from acceptance to resp_valid.
    task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                          input logic [3:0] sz, output logic [63:0] rd, output logic er,
                          output int lat);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_size = sz;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL req_ready_before_accept got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        // Scramble fields after acceptance; they must have no effect.
        req_valid = 1'b0; req_write = ~wr; req_addr = 64'h0; req_wdata = ~wd; req_size = 4'd8;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (resp_valid !== 1'b1) begin
            fails++; $display("FAIL resp_timeout got resp_valid=%b want 1", resp_valid);
        end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        tests++;
        if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL resp_release got v=%b rdy=%b err=%b rd=%h want 0 1 0 0",
                     resp_valid, req_ready, resp_err, resp_rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = 4'd1; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL reset_state got rdy=%b v=%b err=%b rd=%h want 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b1, 64'h10, 64'h1122334455667788, 4'd8, rd, er, lat);
        tests++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'd0) begin
            fails++; $display("FAIL write8 got lat=%0d err=%b rd=%h want 2 0 0", lat, er, rd);
        end
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL read8 got lat=%0d err=%b rd=%h want 2 0 1122334455667788", lat, er, rd);
        end
    endtask

    task automatic test_subword();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 64'h12, 64'h0, 4'd2, rd, er, lat);
        tests++;
        if (er !== 1'b0 || rd !== 64'h5566) begin
            fails++; $display("FAIL read2 got err=%b rd=%h want 0 5566", er, rd);
        end
        // Upper wdata bytes must not leak into neighbouring bytes.
        do_req(1'b1, 64'h13, 64'hDEADBEEF123456FF, 4'd1, rd, er, lat);
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (er !== 1'b0 || rd !== 64'h11223344FF667788) begin
            fails++; $display("FAIL byte_merge got err=%b rd=%h want 0 11223344ff667788", er, rd);
        end
        do_req(1'b0, 64'h14, 64'h0, 4'd4, rd, er, lat);
        tests++;
        if (er !== 1'b0 || rd !== 64'h11223344) begin
            fails++; $display("FAIL read4 got err=%b rd=%h want 0 11223344", er, rd);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 64'h11, 64'h0, 4'd4, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            fails++; $display("FAIL misaligned_read got err=%b rd=%h want 1 0", er, rd);
        end
        do_req(1'b1, 64'h3FC, 64'hFFFFFFFFFFFFFFFF, 4'd8, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL write_3fc got err=%b want 1", er);
        end
        do_req(1'b1, 64'h400, 64'hFFFFFFFF, 4'd4, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL out_of_range got err=%b want 1", er);
        end
        do_req(1'b1, 64'h8000000000000010, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL high_addr got err=%b want 1", er);
        end
        do_req(1'b1, 64'h10, 64'h0, 4'd3, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL size3 got err=%b want 1", er);
        end
        // Last legal doubleword.
        do_req(1'b1, 64'h3F8, 64'h0102030405060708, 4'd8, rd, er, lat);
        do_req(1'b0, 64'h3F8, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (er !== 1'b0 || rd !== 64'h0102030405060708) begin
            fails++; $display("FAIL top_dword got err=%b rd=%h want 0 0102030405060708", er, rd);
        end
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (er !== 1'b0 || rd !== 64'h11223344FF667788) begin
            fails++; $display("FAIL after_errors got err=%b rd=%h want 0 11223344ff667788", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int lat;
        int bad;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        // New write attempt while the response is stalled must be ignored.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h0;
        req_size = 4'd8;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({resp_valid, req_ready, resp_err, resp_rdata} !==
                {1'b1, 1'b0, 1'b0, 64'h11223344FF667788}) bad++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL stall_stable got %0d bad cycles want 0", bad);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        tests++;
        if ({resp_valid, req_ready, resp_rdata} !== {1'b0, 1'b1, 64'd0}) begin
            fails++;
            $display("FAIL stall_release got v=%b rdy=%b rd=%h want 0 1 0",
                     resp_valid, req_ready, resp_rdata);
        end
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        tests++;
        if (rd !== 64'h11223344FF667788) begin
            fails++; $display("FAIL ignored_write got rd=%h want 11223344ff667788", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b1, 64'h20, 64'h5A, 4'd1, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hAA;
        req_size = 4'd1;
        @(posedge clk); #1;          // accepted, WAIT counter=1
        req_valid = 1'b0;
        @(posedge clk); #1;          // WAIT counter=0, commit on next edge
        reset = 1'b1;
        #1;
        tests++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL reset_in_wait got rdy=%b v=%b err=%b rd=%h want 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        do_req(1'b0, 64'h20, 64'h0, 4'd1, rd, er, lat);
        tests++;
        if (rd !== 64'h5A) begin
            fails++; $display("FAIL discarded_write got rd=%h want 5a", rd);
        end
        // Asynchronous clear while a response is being presented.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        tests++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h11223344FF667788) begin
            fails++; $display("FAIL resp_before_reset got v=%b rd=%h", resp_valid, resp_rdata);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({resp_valid, resp_rdata} !== {1'b0, 64'd0}) begin
            fails++; $display("FAIL async_clear got v=%b rd=%h want 0 0", resp_valid, resp_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat;
        int accepts, resps, bad;
        sel = 1'b1;
        do_req(1'b1, 64'h40, 64'hCAFEBABE, 4'd4, rd, er, lat);
        do_req(1'b0, 64'h40, 64'h0, 4'd4, rd, er, lat);
        tests++;
        if (lat !== 0 || er !== 1'b0 || rd !== 64'hCAFEBABE) begin
            fails++; $display("FAIL lat0_read got lat=%0d err=%b rd=%h want 0 0 cafebabe",
                              lat, er, rd);
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40; req_size = 4'd4;
        resp_ready = 1'b1;
        accepts = 0; resps = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready === 1'b1) accepts++;
            if (resp_valid === 1'b1) begin
                resps++;
                if (resp_rdata !== 64'hCAFEBABE) bad++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        tests++;
        if (accepts != 5 || resps != 5 || bad != 0) begin
            fails++; $display("FAIL back_to_back got accepts=%0d resps=%0d bad=%0d want 5 5 0",
                              accepts, resps, bad);
        end
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
